game_ctrl: RTL and testbench

Top-level game sequencer for the slime game. It owns the run state machine (title, play, dying, game over) and the two-digit BCD score counter. It issues the one-cycle slime_die pulse that the score recorder samples. It also selects which two-digit score the seven-segment path displays: highest, current or last.

---
 rtl/game_ctrl.sv | 149 ++++++++++++++
 tb/tb_game_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
//   Top-level sequencer for the slime game. It runs the game state machine
//   (title -> play -> dying -> game over), keeps the two-digit BCD score, emits
//   the one-cycle death pulse that the score recorder samples, and chooses
//   which score the seven-segment path shows.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   btn_start         one-cycle start/restart pulse (already debounced)
//   collide           slime/obstacle collision level, sampled every cycle
//   point             one-cycle pulse when an obstacle is cleared
//   last_score_1/0    last recorded score digits from the recorder (BCD)
//   highest_score_1/0 highest recorded score digits from the recorder (BCD)
//   score_1/0         current score digits (BCD), registered
//   slime_die         one-cycle death pulse, registered
//   state             IDLE=0, PLAY=1, DYING=2, OVER=3, registered
//   play_en           high while playing; gates slime/obstacle motion
//   disp_1/0          digits routed to the seven-segment display
//   new_high          game-over banner flag (current score equals highest)
// -----------------------------------------------------------------------------
module game_ctrl #(
    parameter int DIE_CYCLES = 50_000_000,
    parameter int DIE_W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       collide,
    input  logic       point,
    input  logic [3:0] last_score_0,
    input  logic [3:0] last_score_1,
    input  logic [3:0] highest_score_0,
    input  logic [3:0] highest_score_1,
    output logic [3:0] score_0,
    output logic [3:0] score_1,
    output logic       slime_die,
    output logic [1:0] state,
    output logic       play_en,
    output logic [3:0] disp_0,
    output logic [3:0] disp_1,
    output logic       new_high
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } state_t;

    // The counter starts at 0 on the first DYING cycle, so the last DYING
    // cycle is the one where it reads DIE_CYCLES-1.
    localparam logic [DIE_W-1:0] DIE_LAST = DIE_W'(DIE_CYCLES - 1);

    state_t           state_reg;
    logic [3:0]       score_0_reg;
    logic [3:0]       score_1_reg;
    logic             slime_die_reg;
    logic [DIE_W-1:0] die_cnt_reg;

    logic score_max;
    assign score_max = (score_1_reg == 4'd9) && (score_0_reg == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            score_0_reg   <= 4'd0;
            score_1_reg   <= 4'd0;
            slime_die_reg <= 1'b0;
            die_cnt_reg   <= '0;
        end else begin
            // Death pulse lasts only the first DYING cycle.
            slime_die_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (btn_start) begin
                        state_reg   <= PLAY;
                        score_0_reg <= 4'd0;
                        score_1_reg <= 4'd0;
                    end
                end
                PLAY: begin
                    // Collision beats a simultaneous point so the recorded
                    // score is the one held when the slime was hit.
                    if (collide) begin
                        state_reg     <= DYING;
                        slime_die_reg <= 1'b1;
                        die_cnt_reg   <= '0;
                    end else if (point && !score_max) begin
                        if (score_0_reg == 4'd9) begin
                            score_0_reg <= 4'd0;
                            score_1_reg <= score_1_reg + 4'd1;
                        end else begin
                            score_0_reg <= score_0_reg + 4'd1;
                        end
                    end
                end
                DYING: begin
                    if (die_cnt_reg == DIE_LAST) begin
                        state_reg <= OVER;
                    end else begin
                        die_cnt_reg <= die_cnt_reg + 1'b1;
                    end
                end
                OVER: begin
                    if (btn_start) begin
                        state_reg   <= PLAY;
                        score_0_reg <= 4'd0;
                        score_1_reg <= 4'd0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign score_0   = score_0_reg;
    assign score_1   = score_1_reg;
    assign slime_die = slime_die_reg;
    assign state     = state_reg;
    assign play_en   = (state_reg == PLAY);

    // Title screen shows the record, play/dying show the live score, and the
    // game-over screen shows what the recorder just latched.
    always_comb begin
        disp_0 = score_0_reg;
        disp_1 = score_1_reg;
        case (state_reg)
            IDLE: begin
                disp_0 = highest_score_0;
                disp_1 = highest_score_1;
            end
            OVER: begin
                disp_0 = last_score_0;
                disp_1 = last_score_1;
            end
            default: begin
                disp_0 = score_0_reg;
                disp_1 = score_1_reg;
            end
        endcase
    end

    assign new_high = (state_reg == OVER) &&
                      (score_1_reg == highest_score_1) &&
                      (score_0_reg == highest_score_0);

endmodule

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl
//   Self-checking bench for game_ctrl. Each stimulus cycle pushes the expected
//   post-edge outputs (from a score-as-integer reference model) into a queue;
//   a monitor on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_game_ctrl;

    localparam int DIE_CYCLES = 4;
    localparam int DIE_W      = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       collide = 1'b0;
    logic       point = 1'b0;
    logic [3:0] last_score_0 = 4'd0;
    logic [3:0] last_score_1 = 4'd0;
    logic [3:0] highest_score_0 = 4'd0;
    logic [3:0] highest_score_1 = 4'd0;
    logic [3:0] score_0;
    logic [3:0] score_1;
    logic       slime_die;
    logic [1:0] state;
    logic       play_en;
    logic [3:0] disp_0;
    logic [3:0] disp_1;
    logic       new_high;

    game_ctrl #(.DIE_CYCLES(DIE_CYCLES), .DIE_W(DIE_W)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .collide(collide),
        .point(point), .last_score_0(last_score_0), .last_score_1(last_score_1),
        .highest_score_0(highest_score_0), .highest_score_1(highest_score_1),
        .score_0(score_0), .score_1(score_1), .slime_die(slime_die),
        .state(state), .play_en(play_en), .disp_0(disp_0), .disp_1(disp_1),
        .new_high(new_high)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int score;
        int die;
        int disp;
        int nh;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: mode 0..3, score as a plain integer 0..99.
    int m_mode = 0;
    int m_score = 0;
    int m_pulse = 0;
    int m_dying_cycles = 0;
    int want_hi = 0;
    int want_la = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            int act_disp;
            int act_score;
            e = q.pop_front();
            act_score = 10 * int'(score_1) + int'(score_0);
            act_disp  = 10 * int'(disp_1) + int'(disp_0);
            check("state", int'(state), e.st);
            check("score", act_score, e.score);
            check("slime_die", int'(slime_die), e.die);
            check("play_en", int'(play_en), (e.st == 1) ? 1 : 0);
            check("disp", act_disp, e.disp);
            check("new_high", int'(new_high), e.nh);
            $display("cyc st=%0d score=%0d die=%0d disp=%0d nh=%0d", state,
                     act_score, slime_die, act_disp, new_high);
        end
    end

    task automatic model(input bit s, input bit c, input bit p, input bit r);
        if (r) begin
            m_mode = 0; m_score = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            case (m_mode)
                0: if (s) begin m_mode = 1; m_score = 0; end
                1: begin
                    if (c) begin
                        m_mode = 2; m_pulse = 1; m_dying_cycles = 1;
                    end else if (p && m_score < 99) begin
                        m_score = m_score + 1;
                    end
                end
                2: begin
                    if (m_dying_cycles == DIE_CYCLES) m_mode = 3;
                    else m_dying_cycles++;
                end
                default: if (s) begin m_mode = 1; m_score = 0; end
            endcase
        end
    endtask

    task automatic step(input bit s, input bit c, input bit p, input bit r);
        exp_t e;
        @(negedge clk);
        #1;
        btn_start = s; collide = c; point = p; rst = r;
        highest_score_1 = 4'(want_hi / 10); highest_score_0 = 4'(want_hi % 10);
        last_score_1    = 4'(want_la / 10); last_score_0    = 4'(want_la % 10);
        model(s, c, p, r);
        e.st    = m_mode;
        e.score = m_score;
        e.die   = m_pulse;
        e.disp  = (m_mode == 0) ? want_hi : (m_mode == 3) ? want_la : m_score;
        e.nh    = (m_mode == 3 && m_score == want_hi) ? 1 : 0;
        q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        want_hi = 42; want_la = 17;
        // Reset and start
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 1, 0);            // collide/point ignored in IDLE
        step(1, 0, 0, 0);            // -> PLAY, score 00
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
        step(1, 0, 0, 0);            // start ignored in PLAY
        for (int i = 0; i < 90; i++) step(0, 0, 1, 0);  // saturate at 99
        step(0, 1, 0, 0);            // die at 99
        for (int i = 0; i < DIE_CYCLES + 1; i++) step(0, 0, 0, 0);
        // Restart, score 05, die, new_high banner
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        want_hi = 5; want_la = 5;
        step(0, 1, 0, 0);
        step(1, 0, 1, 0);            // start/point ignored while dying
        for (int i = 0; i < DIE_CYCLES + 1; i++) step(0, 1, 0, 0);
        step(1, 0, 0, 0);            // restart from OVER clears score
        // Collide and point together at 07
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < DIE_CYCLES + 1; i++) step(0, 0, 0, 0);
        // Reset in the second DYING cycle at 04
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        want_hi = 63;
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            bit s, c, p, r;
            s = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) begin
                want_hi = $urandom_range(0, 99);
                want_la = $urandom_range(0, 99);
            end
            if ($urandom_range(0, 29) == 0) want_hi = m_score;
            step(s, c, p, r);
        end
        @(negedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
